// File: rtl/abc_sweep_pkg.sv
// Shared types and constants for the abc_sweep exhaustive truth-table sweeper.
package abc_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam int SETTLE_W = 4;

  // Golden table of y = a~b + ~b~c + ~abc, bit i at {a,b,c} = i
  localparam logic [7:0] EXPECTED_DEFAULT = 8'h39;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/abc_sweep_settle_counter.sv
// Per-vector settle timer: counts up while enabled, flags the sample cycle.
module settle_counter
  import abc_sweep_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) count <= '0;
    else if (en)      count <= count + SETTLE_W'(1);
  end

  assign tc = (count == SETTLE_W'(SETTLE - 1));

endmodule

// File: rtl/abc_sweep.sv
// Drives every {a,b,c} vector into an external function block, captures y
// into an 8-bit truth table and compares it against a golden table.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start; a,b,c = 0
// ST_SETTLE | holding vector {a,b,c} = index, y sampled on the last cycle
// ST_DONE   | one-cycle done pulse, pass/err_count already valid
module abc_sweep
  import abc_sweep_pkg::*;
#(
  parameter int         SETTLE   = 1,
  parameter logic [7:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] y_table,
  output logic       pass,
  output logic [3:0] err_count
);

  state_t     state;
  logic [2:0] index;
  logic       tc;
  logic       cnt_en;
  logic       cnt_clr;
  logic [7:0] table_next;

  assign cnt_en  = (state == ST_SETTLE);
  assign cnt_clr = !cnt_en || tc;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (tc)
  );

  // Table including this cycle's sample, so pass/err_count land with done
  always_comb begin
    table_next        = y_table;
    table_next[index] = y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      index     <= '0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      y_table   <= '0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_SETTLE;
            index     <= '0;
            {a, b, c} <= 3'b000;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
          end
        end
        ST_SETTLE: begin
          if (tc) begin
            y_table <= table_next;
            if (index == 3'd7) begin
              state     <= ST_DONE;
              index     <= '0;
              {a, b, c} <= 3'b000;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (table_next == EXPECTED);
              err_count <= popcount8(table_next ^ EXPECTED);
            end else begin
              index     <= index + 3'd1;
              {a, b, c} <= index + 3'd1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abc_sweep.sv
// Directed bench for abc_sweep: two instances (SETTLE=1 and SETTLE=3) each
// driving a behavioural function block whose response mode is selectable.
module tb_abc_sweep;

  logic       clk;
  int         vectors;
  int         miscompares;
  int         y_mode;

  logic       reset1, start1, y1, a1, b1, c1, busy1, done1, pass1;
  logic [7:0] table1;
  logic [3:0] err1;

  logic       reset3, start3, y3, a3, b3, c3, busy3, done3, pass3;
  logic [7:0] table3;
  logic [3:0] err3;

  abc_sweep #(.SETTLE(1)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
    .y_table(table1), .pass(pass1), .err_count(err1)
  );

  abc_sweep #(.SETTLE(3)) u3 (
    .clk(clk), .reset(reset3), .start(start3), .y(y3),
    .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
    .y_table(table3), .pass(pass3), .err_count(err3)
  );

  function automatic logic f_block(input logic a, input logic b, input logic c);
    return (a & ~b) | (~b & ~c) | (~a & b & c);
  endfunction

  // y_mode: 0 correct block, 1 stuck at 0, 2 inverted
  always_comb begin
    y1 = f_block(a1, b1, c1);
    y3 = f_block(a3, b3, c3);
    if (y_mode == 1) begin
      y1 = 1'b0;
      y3 = 1'b0;
    end else if (y_mode == 2) begin
      y1 = ~f_block(a1, b1, c1);
      y3 = ~f_block(a3, b3, c3);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done1(output int lat);
    lat = 1;
    while (!done1 && lat < 200) begin
      cyc();
      lat++;
    end
    if (!done1) lat = -1;
  endtask

  task automatic sweep1(output int lat);
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    wait_done1(lat);
  endtask

  task automatic test_reset;
    reset1 = 1'b1;
    reset3 = 1'b1;
    cyc();
    cyc();
    reset1 = 1'b0;
    reset3 = 1'b0;
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", busy1); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done1); end
    vectors++; if (table1 !== 8'h00) begin miscompares++; $display("FAIL rst_table got %h want 00", table1); end
    vectors++; if (pass1 !== 1'b0) begin miscompares++; $display("FAIL rst_pass got %b want 0", pass1); end
    vectors++; if (err1 !== 4'd0) begin miscompares++; $display("FAIL rst_err got %0d want 0", err1); end
    vectors++; if ({a1, b1, c1} !== 3'b000) begin miscompares++; $display("FAIL rst_abc got %b want 000", {a1, b1, c1}); end
    vectors++; if (busy3 !== 1'b0 || table3 !== 8'h00) begin miscompares++; $display("FAIL rst_u3 got busy %b table %h want 0 00", busy3, table3); end
  endtask

  task automatic test_correct;
    y_mode = 0;
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({a1, b1, c1} !== 3'(i) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        miscompares++;
        $display("FAIL correct_vec%0d got abc %b busy %b done %b want %b 1 0", i, {a1, b1, c1}, busy1, done1, 3'(i));
      end
      cyc();
    end
    vectors++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin miscompares++; $display("FAIL correct_done got done %b busy %b want 1 0", done1, busy1); end
    vectors++; if (table1 !== 8'h39) begin miscompares++; $display("FAIL correct_table got %h want 39", table1); end
    vectors++; if (pass1 !== 1'b1 || err1 !== 4'd0) begin miscompares++; $display("FAIL correct_pass got pass %b err %0d want 1 0", pass1, err1); end
    vectors++; if ({a1, b1, c1} !== 3'b000) begin miscompares++; $display("FAIL correct_abc_idle got %b want 000", {a1, b1, c1}); end
    cyc();
    vectors++; if (done1 !== 1'b0 || pass1 !== 1'b1) begin miscompares++; $display("FAIL correct_pulse got done %b pass %b want 0 1", done1, pass1); end
  endtask

  task automatic test_zero;
    int lat;
    y_mode = 1;
    cyc();
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    vectors++; if (pass1 !== 1'b0 || err1 !== 4'd0 || busy1 !== 1'b1) begin miscompares++; $display("FAIL zero_start_clear got pass %b err %0d busy %b want 0 0 1", pass1, err1, busy1); end
    wait_done1(lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL zero_latency got %0d want 9", lat); end
    vectors++; if (table1 !== 8'h00) begin miscompares++; $display("FAIL zero_table got %h want 00", table1); end
    vectors++; if (pass1 !== 1'b0 || err1 !== 4'd4) begin miscompares++; $display("FAIL zero_err got pass %b err %0d want 0 4", pass1, err1); end
    cyc();
  endtask

  task automatic test_inverted;
    int lat;
    y_mode = 2;
    sweep1(lat);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL inv_latency got %0d want 9", lat); end
    vectors++; if (table1 !== 8'hC6) begin miscompares++; $display("FAIL inv_table got %h want c6", table1); end
    vectors++; if (pass1 !== 1'b0 || err1 !== 4'd8) begin miscompares++; $display("FAIL inv_err got pass %b err %0d want 0 8", pass1, err1); end
    cyc();
    y_mode = 0;
  endtask

  task automatic test_settle3;
    int n;
    y_mode = 0;
    start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      vectors++;
      if ({a3, b3, c3} !== 3'(i / 3) || busy3 !== 1'b1) begin
        miscompares++;
        $display("FAIL s3_hold%0d got abc %b busy %b want %b 1", i, {a3, b3, c3}, busy3, 3'(i / 3));
      end
      cyc();
    end
    n = 25;
    vectors++; if (done3 !== 1'b1) begin miscompares++; $display("FAIL s3_done_cycle%0d got %b want 1", n, done3); end
    vectors++; if (table3 !== 8'h39 || pass3 !== 1'b1 || err3 !== 4'd0) begin miscompares++; $display("FAIL s3_result got table %h pass %b err %0d want 39 1 0", table3, pass3, err3); end
    cyc();
    vectors++; if (done3 !== 1'b0) begin miscompares++; $display("FAIL s3_pulse got %b want 0", done3); end
  endtask

  task automatic test_reset_mid;
    int pulses;
    int lat;
    y_mode = 0;
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    vectors++; if ({a1, b1, c1} !== 3'd4) begin miscompares++; $display("FAIL mid_index got %b want 100", {a1, b1, c1}); end
    reset1 = 1'b1;
    cyc();
    reset1 = 1'b0;
    vectors++; if (busy1 !== 1'b0 || table1 !== 8'h00 || {a1, b1, c1} !== 3'b000) begin miscompares++; $display("FAIL mid_reset got busy %b table %h abc %b want 0 00 000", busy1, table1, {a1, b1, c1}); end
    vectors++; if (pass1 !== 1'b0 || err1 !== 4'd0) begin miscompares++; $display("FAIL mid_reset_status got pass %b err %0d want 0 0", pass1, err1); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done1) pulses++;
      cyc();
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_no_done got %0d pulses want 0", pulses); end
    reset1 = 1'b1;
    start1 = 1'b1;
    cyc();
    reset1 = 1'b0;
    start1 = 1'b0;
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_priority got busy %b want 0", busy1); end
    cyc();
    sweep1(lat);
    vectors++; if (lat !== 9 || table1 !== 8'h39 || pass1 !== 1'b1) begin miscompares++; $display("FAIL mid_resweep got lat %0d table %h pass %b want 9 39 1", lat, table1, pass1); end
    cyc();
  endtask

  task automatic test_start_held;
    int pulses;
    int t[4];
    pulses = 0;
    for (int k = 0; k < 4; k++) t[k] = -1;
    start1 = 1'b1;
    cyc();
    for (int n = 1; n <= 35; n++) begin
      if (done1) begin
        if (pulses < 4) t[pulses] = n;
        pulses++;
      end
      cyc();
    end
    start1 = 1'b0;
    vectors++; if (pulses !== 3) begin miscompares++; $display("FAIL held_count got %0d want 3", pulses); end
    vectors++; if (t[0] !== 9) begin miscompares++; $display("FAIL held_first got %0d want 9", t[0]); end
    vectors++; if (t[1] !== 19 || t[2] !== 29) begin miscompares++; $display("FAIL held_period got %0d %0d want 19 29", t[1], t[2]); end
    for (int i = 0; i < 15; i++) cyc();
    vectors++; if (busy1 !== 1'b0 || table1 !== 8'h39) begin miscompares++; $display("FAIL held_drain got busy %b table %h want 0 39", busy1, table1); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    y_mode      = 0;
    reset1      = 1'b1;
    reset3      = 1'b1;
    start1      = 1'b0;
    start3      = 1'b0;
    test_reset();
    test_correct();
    test_zero();
    test_inverted();
    test_settle3();
    test_reset_mid();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
